snax_dream_ctrl: RTL and testbench

Sequencer for the DREAM accelerator shell. It accepts a job from the CSR manager (beat count, mode, outstanding limit) and joins the two streamer input streams into single datapath issue handshakes. It counts issued and retired beats, throttles outstanding beats, and reports busy status and a cycle count on the read-only CSRs. It sits between the CSR manager/streamer handshakes and the DREAM datapath; data buses bypass it, and only valid/ready and control pass through.

---
 rtl/snax_dream_ctrl_if.sv | 37 +++
 rtl/snax_dream_ctrl.sv | 115 +++++++++++
 tb/tb_snax_dream_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snax_dream_ctrl_if.sv
// Handshake/control bundle between the DREAM shell environment and its sequencer.
// Data buses bypass this bundle; only CSR words, valid/ready and mode travel here.
interface snax_dream_ctrl_if #(
    parameter int unsigned RegRWCount   = 3,
    parameter int unsigned RegROCount   = 2,
    parameter int unsigned RegDataWidth = 32
);
    logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_i;
    logic                               csr_reg_set_valid_i;
    logic                               csr_reg_set_ready_o;
    logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_o;
    logic                               stream2acc_0_valid_i;
    logic                               stream2acc_0_ready_o;
    logic                               stream2acc_1_valid_i;
    logic                               stream2acc_1_ready_o;
    logic                               acc2stream_0_valid_o;
    logic                               acc2stream_0_ready_i;
    logic                               dp_in_valid_o;
    logic                               dp_in_ready_i;
    logic                               dp_out_valid_i;
    logic                               dp_out_ready_o;
    logic                               dp_mode_o;

    modport master (
        output csr_reg_set_i, csr_reg_set_valid_i, stream2acc_0_valid_i, stream2acc_1_valid_i,
               acc2stream_0_ready_i, dp_in_ready_i, dp_out_valid_i,
        input  csr_reg_set_ready_o, csr_reg_ro_set_o, stream2acc_0_ready_o, stream2acc_1_ready_o,
               acc2stream_0_valid_o, dp_in_valid_o, dp_out_ready_o, dp_mode_o
    );

    modport slave (
        input  csr_reg_set_i, csr_reg_set_valid_i, stream2acc_0_valid_i, stream2acc_1_valid_i,
               acc2stream_0_ready_i, dp_in_ready_i, dp_out_valid_i,
        output csr_reg_set_ready_o, csr_reg_ro_set_o, stream2acc_0_ready_o, stream2acc_1_ready_o,
               acc2stream_0_valid_o, dp_in_valid_o, dp_out_ready_o, dp_mode_o
    );
endinterface

// File: rtl/snax_dream_ctrl.sv
// DREAM shell sequencer: accepts a job, joins the two input streams into datapath
// issues, throttles outstanding beats and reports busy/done and job cycle count.
module snax_dream_ctrl #(
    parameter int unsigned RegRWCount     = 3,
    parameter int unsigned RegROCount     = 2,
    parameter int unsigned RegDataWidth   = 32,
    parameter int unsigned CntWidth       = 32,
    parameter int unsigned MaxOutstanding = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    snax_dream_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state;
    logic [CntWidth-1:0] n_q, l_eff_q, issue_cnt, retire_cnt, cyc_cnt, cyc_last_q;
    logic                mode_q, done_q, busy_q;

    logic [CntWidth-1:0] job_n, job_l, outstanding;
    logic                can_issue, issue_fire, retire_ok, retire_fire, job_fire;
    logic [RegROCount*RegDataWidth-1:0] ro_set;
    logic                unused_set;

    function automatic logic [CntWidth-1:0] clamp_limit(input logic [CntWidth-1:0] l);
        if (l == '0 || l > CntWidth'(MaxOutstanding)) return CntWidth'(MaxOutstanding);
        return l;
    endfunction

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign job_n       = bus.csr_reg_set_i[CntWidth-1:0];
    assign job_l       = bus.csr_reg_set_i[2*RegDataWidth +: CntWidth];
    assign unused_set  = ^bus.csr_reg_set_i;
    assign outstanding = issue_cnt - retire_cnt;

    assign can_issue = (state == RUN) && (outstanding < l_eff_q);
    // Each stream's ready depends only on the other stream's valid, so A and B fire together.
    assign bus.dp_in_valid_o        = can_issue & bus.stream2acc_0_valid_i & bus.stream2acc_1_valid_i;
    assign bus.stream2acc_0_ready_o = can_issue & bus.stream2acc_1_valid_i & bus.dp_in_ready_i;
    assign bus.stream2acc_1_ready_o = can_issue & bus.stream2acc_0_valid_i & bus.dp_in_ready_i;
    assign issue_fire               = bus.dp_in_valid_o & bus.dp_in_ready_i;

    // A result with nothing outstanding is a protocol error and is swallowed.
    assign retire_ok                = (state != IDLE) && (outstanding != '0);
    assign bus.acc2stream_0_valid_o = retire_ok & bus.dp_out_valid_i;
    assign bus.dp_out_ready_o       = (state != IDLE) & bus.acc2stream_0_ready_i;
    assign retire_fire              = bus.acc2stream_0_valid_o & bus.acc2stream_0_ready_i;

    assign bus.csr_reg_set_ready_o = (state == IDLE);
    assign job_fire                = bus.csr_reg_set_valid_i & bus.csr_reg_set_ready_o;
    assign bus.dp_mode_o           = mode_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            n_q        <= '0;
            l_eff_q    <= '0;
            mode_q     <= 1'b0;
            issue_cnt  <= '0;
            retire_cnt <= '0;
            cyc_cnt    <= '0;
            cyc_last_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (job_fire) begin
                        n_q        <= job_n;
                        mode_q     <= bus.csr_reg_set_i[RegDataWidth];
                        l_eff_q    <= clamp_limit(job_l);
                        issue_cnt  <= '0;
                        retire_cnt <= '0;
                        cyc_cnt    <= '0;
                        if (job_n == '0) begin
                            done_q     <= 1'b1;
                            cyc_last_q <= '0;
                        end else begin
                            done_q <= 1'b0;
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                default: begin
                    cyc_cnt <= sat_inc(cyc_cnt);
                    if (issue_fire)  issue_cnt  <= issue_cnt + 1'b1;
                    if (retire_fire) retire_cnt <= retire_cnt + 1'b1;
                    if (state == RUN && issue_fire && (issue_cnt + 1'b1) == n_q)
                        state <= DRAIN;
                    // Completion is seen the cycle after the last retire, hence the +1.
                    if (state == DRAIN && retire_cnt == n_q) begin
                        state      <= IDLE;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        cyc_last_q <= sat_inc(cyc_cnt);
                    end
                end
            endcase
        end
    end

    always_comb begin
        ro_set                           = '0;
        ro_set[1:0]                      = {done_q, busy_q};
        ro_set[RegDataWidth +: CntWidth] = cyc_last_q;
    end

    assign bus.csr_reg_ro_set_o = ro_set;

endmodule

// File: tb/tb_snax_dream_ctrl.sv
// Directed bench for snax_dream_ctrl: expected issue/retire cycles are queued by the
// stimulus and consumed by an independent monitor; CSR/status values checked directly.
module tb_snax_dream_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   pending = 0;
    logic hold, pulse, force_out;
    int   exp_issue[$];
    int   exp_retire[$];

    snax_dream_ctrl_if #(.RegRWCount(3), .RegROCount(2), .RegDataWidth(32)) bus ();

    snax_dream_ctrl #(
        .RegRWCount(3), .RegROCount(2), .RegDataWidth(32), .CntWidth(32), .MaxOutstanding(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    wire issue_fire  = bus.dp_in_valid_o & bus.dp_in_ready_i;
    wire retire_fire = bus.acc2stream_0_valid_o & bus.acc2stream_0_ready_i;
    wire dp_out_fire = bus.dp_out_valid_i & bus.dp_out_ready_o;
    wire a_fire      = bus.stream2acc_0_valid_i & bus.stream2acc_0_ready_o;
    wire b_fire      = bus.stream2acc_1_valid_i & bus.stream2acc_1_ready_o;

    // Datapath model: holds accepted beats and returns them when not held.
    assign bus.dp_out_valid_i = force_out || ((pending > 0) && (!hold || pulse));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) pending <= 0;
        else     pending <= pending + (issue_fire ? 1 : 0) - (dp_out_fire ? 1 : 0);
    end

    initial forever begin
        @(negedge clk);
        if (a_fire || b_fire) begin
            tests++;
            if (!(a_fire && b_fire && issue_fire)) begin
                fails++;
                $display("FAIL join cyc=%0d: a_fire=%0b b_fire=%0b issue=%0b, required all 1",
                         cyc, a_fire, b_fire, issue_fire);
            end
        end
        if (issue_fire) begin
            tests++;
            if (exp_issue.size() == 0) begin
                fails++;
                $display("FAIL issue cyc=%0d: unexpected issue fire, required none", cyc);
            end else begin
                int e;
                e = exp_issue.pop_front();
                if (e != cyc) begin
                    fails++;
                    $display("FAIL issue: fired at cyc %0d, required cyc %0d", cyc, e);
                end
            end
        end
        if (retire_fire) begin
            tests++;
            if (exp_retire.size() == 0) begin
                fails++;
                $display("FAIL retire cyc=%0d: unexpected retire fire, required none", cyc);
            end else begin
                int e;
                e = exp_retire.pop_front();
                if (e != cyc) begin
                    fails++;
                    $display("FAIL retire: fired at cyc %0d, required cyc %0d", cyc, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic job(input int n, input int m, input int l);
        bus.csr_reg_set_i       = {32'(l), 32'(m), 32'(n)};
        bus.csr_reg_set_valid_i = 1'b1;
        goto(cyc + 1);
        bus.csr_reg_set_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] ro(input int idx);
        logic [63:0] v;
        v = bus.csr_reg_ro_set_o;
        return v[idx*32 +: 32];
    endfunction

    initial begin
        int c;
        rst = 1'b1;
        hold = 1'b0;
        pulse = 1'b0;
        force_out = 1'b1;
        bus.csr_reg_set_i        = {32'd0, 32'd1, 32'd4};
        bus.csr_reg_set_valid_i  = 1'b1;
        bus.stream2acc_0_valid_i = 1'b1;
        bus.stream2acc_1_valid_i = 1'b1;
        bus.acc2stream_0_ready_i = 1'b1;
        bus.dp_in_ready_i        = 1'b1;

        // Reset with every valid asserted
        goto(2);
        @(negedge clk);
        chk("rst_set_ready", bus.csr_reg_set_ready_o, 1);
        chk("rst_s0_ready", bus.stream2acc_0_ready_o, 0);
        chk("rst_s1_ready", bus.stream2acc_1_ready_o, 0);
        chk("rst_dp_in_valid", bus.dp_in_valid_o, 0);
        chk("rst_acc_valid", bus.acc2stream_0_valid_o, 0);
        chk("rst_dp_out_ready", bus.dp_out_ready_o, 0);
        chk("rst_mode", bus.dp_mode_o, 0);
        chk("rst_ro0", ro(0), 0);
        chk("rst_ro1", ro(1), 0);
        goto(3);
        rst = 1'b0;
        force_out = 1'b0;
        bus.csr_reg_set_valid_i = 1'b0;

        // N=4, L=0, both streams always valid, 1-cycle echo
        c = cyc;
        for (int i = 1; i <= 4; i++) exp_issue.push_back(c + i);
        for (int i = 2; i <= 5; i++) exp_retire.push_back(c + i);
        job(4, 0, 0);
        goto(c + 6);
        @(negedge clk);
        chk("n4_busy", ro(0), 32'b01);
        goto(c + 7);
        @(negedge clk);
        chk("n4_ro0", ro(0), 32'b10);
        chk("n4_ro1", ro(1), 6);
        chk("n4_set_ready", bus.csr_reg_set_ready_o, 1);
        chk("n4_issue_q", exp_issue.size(), 0);
        chk("n4_retire_q", exp_retire.size(), 0);

        // N=3, only A valid for 5 cycles, then B joins
        goto(cyc + 1);
        c = cyc;
        bus.stream2acc_1_valid_i = 1'b0;
        for (int i = 6; i <= 8; i++) exp_issue.push_back(c + i);
        for (int i = 7; i <= 9; i++) exp_retire.push_back(c + i);
        job(3, 0, 0);
        goto(c + 3);
        @(negedge clk);
        chk("aonly_s0_ready", bus.stream2acc_0_ready_o, 0);
        chk("aonly_dp_in_valid", bus.dp_in_valid_o, 0);
        goto(c + 6);
        bus.stream2acc_1_valid_i = 1'b1;
        goto(c + 11);
        @(negedge clk);
        chk("aonly_ro0", ro(0), 32'b10);
        chk("aonly_ro1", ro(1), 10);

        // N=10, L=2, datapath withholds results
        goto(cyc + 1);
        c = cyc;
        hold = 1'b1;
        exp_issue.push_back(c + 1);
        exp_issue.push_back(c + 2);
        exp_issue.push_back(c + 6);
        for (int i = 10; i <= 16; i++) exp_issue.push_back(c + i);
        exp_retire.push_back(c + 5);
        for (int i = 9; i <= 17; i++) exp_retire.push_back(c + i);
        job(10, 0, 2);
        goto(c + 4);
        @(negedge clk);
        chk("lim_stall", bus.dp_in_valid_o, 0);
        goto(c + 5);
        pulse = 1'b1;
        goto(c + 6);
        pulse = 1'b0;
        goto(c + 8);
        @(negedge clk);
        chk("lim_stall2", bus.dp_in_valid_o, 0);
        chk("lim_issued", exp_issue.size(), 7);
        goto(c + 9);
        hold = 1'b0;
        goto(c + 19);
        @(negedge clk);
        chk("lim_ro0", ro(0), 32'b10);
        chk("lim_ro1", ro(1), 18);

        // N=0 completes immediately without handshakes
        goto(cyc + 1);
        c = cyc;
        job(0, 0, 0);
        @(negedge clk);
        chk("n0_ro0", ro(0), 32'b10);
        chk("n0_ro1", ro(1), 0);
        chk("n0_set_ready", bus.csr_reg_set_ready_o, 1);

        // Reset mid-job after two beats, then a fresh N=1 job
        goto(cyc + 1);
        c = cyc;
        exp_issue.push_back(c + 1);
        exp_issue.push_back(c + 2);
        exp_retire.push_back(c + 2);
        job(5, 0, 0);
        goto(c + 2);
        rst = 1'b1;
        goto(c + 3);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_set_ready", bus.csr_reg_set_ready_o, 1);
        chk("abort_dp_in_valid", bus.dp_in_valid_o, 0);
        chk("abort_s0_ready", bus.stream2acc_0_ready_o, 0);
        chk("abort_acc_valid", bus.acc2stream_0_valid_o, 0);
        chk("abort_ro0", ro(0), 0);

        goto(cyc + 1);
        c = cyc;
        exp_issue.push_back(c + 1);
        exp_retire.push_back(c + 2);
        job(1, 1, 0);
        @(negedge clk);
        chk("n1_mode", bus.dp_mode_o, 1);
        goto(c + 4);
        @(negedge clk);
        chk("n1_ro0", ro(0), 32'b10);
        chk("n1_ro1", ro(1), 3);

        chk("end_issue_q", exp_issue.size(), 0);
        chk("end_retire_q", exp_retire.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
